// File: rtl/alu_arbiter.sv
// alu_arbiter: lets two requesters share one combinational ALU.
// A winner is picked in IDLE (fixed priority or round-robin). Its operands
// are latched onto the ALU inputs. One cycle later the ALU outputs are
// captured, and the response is held until the consumer takes it.
module alu_arbiter #(
  parameter int FIXED_PRIO = 0  // 0: round-robin, 1: requester 0 always wins
) (
  input  logic       clk,
  input  logic       rst_n,
  // requester 0
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [3:0] req0_op,
  // requester 1
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [3:0] req1_op,
  // shared ALU
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_opcode,
  input  logic [7:0] alu_result,
  input  logic       alu_zero,
  input  logic       alu_carry,
  // response
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_result,
  output logic       rsp_zero,
  output logic       rsp_carry,
  output logic       rsp_err,
  output logic       busy
);

  // Highest opcode the ALU defines; anything above it is flagged as an error.
  localparam logic [3:0] LAST_LEGAL_OP = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t     state_q;
  logic       busy_q;
  logic       rr_pref_q;   // requester favoured when both are valid
  logic       id_q;        // requester that owns the in-flight operation
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [3:0] alu_opcode_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic [7:0] rsp_result_q;
  logic       rsp_zero_q;
  logic       rsp_carry_q;
  logic       rsp_err_q;

  // Arbitration result for the current cycle
  logic       grant_valid_d;
  logic       grant_id_d;
  logic       accept_d;
  logic [7:0] acc_a_d;
  logic [7:0] acc_b_d;
  logic [3:0] acc_op_d;

  // Pick a winner among the valid requesters. Whether anyone is valid does
  // not depend on the policy; only the tie-break does.
  always_comb begin
    grant_valid_d = req0_valid | req1_valid;
    grant_id_d    = 1'b0;
    if (FIXED_PRIO != 0) begin
      // requester 0 wins whenever it asks
      grant_id_d = ~req0_valid;
    end else if (req0_valid && req1_valid) begin
      // tie goes to whoever was not served last
      grant_id_d = rr_pref_q;
    end else begin
      grant_id_d = req1_valid;
    end
  end

  // Readies are only offered in IDLE, and only to the winner. Also mux the
  // winner's operation so the FSM can latch it.
  always_comb begin
    req0_ready = (state_q == ST_IDLE) && grant_valid_d && !grant_id_d;
    req1_ready = (state_q == ST_IDLE) && grant_valid_d &&  grant_id_d;
    accept_d   = req0_ready | req1_ready;
    if (grant_id_d) begin
      acc_a_d  = req1_a;
      acc_b_d  = req1_b;
      acc_op_d = req1_op;
    end else begin
      acc_a_d  = req0_a;
      acc_b_d  = req0_b;
      acc_op_d = req0_op;
    end
  end

  // Controller FSM. Every output apart from the readies comes straight from
  // a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      rr_pref_q    <= 1'b0;
      id_q         <= 1'b0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_opcode_q <= 4'h0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= 8'h00;
      rsp_zero_q   <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            // The ALU inputs stay frozen from here until IDLE is reached again.
            alu_a_q      <= acc_a_d;
            alu_b_q      <= acc_b_d;
            alu_opcode_q <= acc_op_d;
            id_q         <= grant_id_d;
            // The pointer moves only when a request is actually accepted.
            rr_pref_q    <= ~grant_id_d;
            busy_q       <= 1'b1;
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // The ALU has had a full cycle on stable inputs, so capture its outputs.
          // Illegal opcodes still execute; they are only flagged here.
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_carry_q  <= alu_carry;
          rsp_err_q    <= (alu_opcode_q > LAST_LEGAL_OP);
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: begin
          // Hold the response until the consumer takes it.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_opcode_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter. Two instances (round-robin and fixed priority) share
// one stimulus stream. Each instance has its own small ALU model. A monitor
// keeps a per-instance transaction model and scoreboard.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       req0_valid = 1'b0, req1_valid = 1'b0, rsp_ready = 1'b1;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0] req0_op = '0, req1_op = '0;

  logic       req0_ready_w [2];
  logic       req1_ready_w [2];
  logic [7:0] alu_a_w      [2];
  logic [7:0] alu_b_w      [2];
  logic [3:0] alu_op_w     [2];
  logic [7:0] alu_res_w    [2];
  logic       alu_zero_w   [2];
  logic       alu_carry_w  [2];
  logic       rsp_valid_w  [2];
  logic       rsp_id_w     [2];
  logic [7:0] rsp_result_w [2];
  logic       rsp_zero_w   [2];
  logic       rsp_carry_w  [2];
  logic       rsp_err_w    [2];
  logic       busy_w       [2];

  // Reference ALU, returned as {carry, result}. Undefined opcodes give 0.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] op);
    logic [8:0] r;
    case (op)
      4'h0: r = {1'b0, a} + {1'b0, b};
      4'h1: r = {1'b0, a} - {1'b0, b};
      4'h2: r = {1'b0, a & b};
      4'h3: r = {1'b0, a | b};
      4'h4: r = {1'b0, a ^ b};
      4'h5: r = {1'b0, ~a};
      4'h6: r = {a, 1'b0};
      4'h7: r = {a[0], 1'b0, a[7:1]};
      4'h8: r = {1'b0, a} + 9'd1;
      4'h9: r = {1'b0, a} - 9'd1;
      4'hA: r = {1'b0, b};
      default: r = 9'h000;
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [8:0] alu_full;
    assign alu_full        = alu_ref(alu_a_w[gi], alu_b_w[gi], alu_op_w[gi]);
    assign alu_res_w[gi]   = alu_full[7:0];
    assign alu_carry_w[gi] = alu_full[8];
    assign alu_zero_w[gi]  = (alu_full[7:0] == 8'h00);

    alu_arbiter #(.FIXED_PRIO(gi)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready_w[gi]),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready_w[gi]),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(alu_a_w[gi]), .alu_b(alu_b_w[gi]), .alu_opcode(alu_op_w[gi]),
      .alu_result(alu_res_w[gi]), .alu_zero(alu_zero_w[gi]), .alu_carry(alu_carry_w[gi]),
      .rsp_valid(rsp_valid_w[gi]), .rsp_ready(rsp_ready), .rsp_id(rsp_id_w[gi]),
      .rsp_result(rsp_result_w[gi]), .rsp_zero(rsp_zero_w[gi]),
      .rsp_carry(rsp_carry_w[gi]), .rsp_err(rsp_err_w[gi]), .busy(busy_w[gi])
    );
  end

  typedef struct packed {
    logic       id;
    logic [7:0] result;
    logic       zero;
    logic       carry;
    logic       err;
  } exp_t;

  // Scoreboard and transaction-level model, one per instance
  exp_t       sbq [2][$];
  bit         m_idle [2] = '{1'b1, 1'b1};
  int         m_age  [2] = '{0, 0};
  bit         m_pref [2] = '{1'b0, 1'b0};
  logic [7:0] m_a    [2];
  logic [7:0] m_b    [2];
  logic [3:0] m_op   [2];

  int n_cmp = 0;
  int n_bad = 0;
  bit done_req = 1'b0;
  bit done_ack = 1'b0;

  // Monitor scratch
  bit         v0, v1, has_w, wid, er0, er1;
  logic [8:0] r9;
  logic [7:0] wa, wb;
  logic [3:0] wop;
  exp_t       e;

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s dut%0d @%0t: actual %0h required %0h", name, inst, $time, act, req);
    end
  endtask

  // Monitor: sample 2 ns after each falling edge, once inputs have settled.
  // Check every output against the model. Predict acceptances and push the
  // expected response. Pop the scoreboard on each response handshake.
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        chk("reset_state", i,
            32'({alu_a_w[i], alu_b_w[i], alu_op_w[i], rsp_valid_w[i], rsp_id_w[i],
                 rsp_result_w[i], rsp_zero_w[i], rsp_carry_w[i], rsp_err_w[i], busy_w[i]}),
            32'h0);
        m_idle[i] = 1'b1;
        m_age[i]  = 0;
        m_pref[i] = 1'b0;
        sbq[i].delete();
      end else begin
        if (!m_idle[i]) m_age[i]++;
        v0    = req0_valid;
        v1    = req1_valid;
        has_w = v0 | v1;
        if (i == 1)        wid = !v0;
        else if (v0 && v1) wid = m_pref[i];
        else               wid = !v0;
        er0 = m_idle[i] && has_w && !wid;
        er1 = m_idle[i] && has_w && wid;
        chk("req_ready", i, 32'({req0_ready_w[i], req1_ready_w[i]}), 32'({er0, er1}));
        chk("busy", i, 32'(busy_w[i]), 32'(!m_idle[i]));
        chk("rsp_valid", i, 32'(rsp_valid_w[i]), 32'(!m_idle[i] && m_age[i] >= 2));
        if (!m_idle[i])
          chk("alu_inputs", i, 32'({alu_a_w[i], alu_b_w[i], alu_op_w[i]}),
              32'({m_a[i], m_b[i], m_op[i]}));
        if (!m_idle[i] && m_age[i] >= 2) begin
          if (sbq[i].size() > 0) begin
            e = sbq[i][0];
            chk("rsp_fields", i,
                32'({rsp_id_w[i], rsp_result_w[i], rsp_zero_w[i], rsp_carry_w[i], rsp_err_w[i]}),
                32'(e));
            if (rsp_ready) begin
              $display("rsp dut%0d id=%0d result=%02h z=%0d c=%0d err=%0d", i,
                       rsp_id_w[i], rsp_result_w[i], rsp_zero_w[i], rsp_carry_w[i], rsp_err_w[i]);
              void'(sbq[i].pop_front());
              m_idle[i] = 1'b1;
              m_age[i]  = 0;
            end
          end
        end else if (m_idle[i] && has_w) begin
          wa  = wid ? req1_a  : req0_a;
          wb  = wid ? req1_b  : req0_b;
          wop = wid ? req1_op : req0_op;
          r9  = alu_ref(wa, wb, wop);
          e.id     = wid;
          e.result = r9[7:0];
          e.zero   = (r9[7:0] == 8'h00);
          e.carry  = r9[8];
          e.err    = (wop > 4'd10);
          sbq[i].push_back(e);
          m_idle[i] = 1'b0;
          m_age[i]  = 0;
          m_pref[i] = !wid;
          m_a[i]    = wa;
          m_b[i]    = wb;
          m_op[i]   = wop;
        end
      end
      if (done_req && !done_ack)
        chk("sb_drained", i, 32'(sbq[i].size()), 32'd0);
    end
    if (done_req) done_ack = 1'b1;
  end

  task automatic idle_cycles(input int n);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic rand_ops();
    req0_a  = 8'($urandom); req0_b = 8'($urandom); req0_op = 4'($urandom_range(0, 15));
    req1_a  = 8'($urandom); req1_b = 8'($urandom); req1_op = 4'($urandom_range(0, 15));
  endtask

  // Stimulus: directed scenarios first, then a long randomized run
  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single op, 0x0F + 0x01
    req0_valid = 1'b1; req0_a = 8'h0F; req0_b = 8'h01; req0_op = 4'h0;
    @(negedge clk);
    idle_cycles(5);

    // contention, both requesters valid continuously
    for (int k = 0; k < 14; k++) begin
      rand_ops(); req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
    end
    idle_cycles(5);

    // backpressure: response held for several cycles while requester 1 waits
    req0_valid = 1'b1; req0_a = 8'h80; req0_b = 8'h80; req0_op = 4'h0;
    @(negedge clk);
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h05; req1_b = 8'h03; req1_op = 4'h1;
    repeat (8) @(negedge clk);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    idle_cycles(5);

    // illegal opcode from requester 1
    req1_valid = 1'b1; req1_a = 8'h33; req1_b = 8'h44; req1_op = 4'hC;
    @(negedge clk);
    idle_cycles(5);

    // randomized traffic with random backpressure
    for (int k = 0; k < 1500; k++) begin
      rand_ops();
      req0_valid = ($urandom_range(0, 99) < 55);
      req1_valid = ($urandom_range(0, 99) < 55);
      rsp_ready  = ($urandom_range(0, 99) < 70);
      @(negedge clk);
    end
    idle_cycles(5);

    // reset while the operation is in EXEC
    req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h01; req0_op = 4'h0;
    @(negedge clk);
    rst_n = 1'b0; req0_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(6);

    // contention straight after reset: the pointer starts on requester 0
    for (int k = 0; k < 8; k++) begin
      rand_ops(); req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
    end
    for (int k = 0; k < 200; k++) begin
      rand_ops();
      req0_valid = ($urandom_range(0, 99) < 40);
      req1_valid = ($urandom_range(0, 99) < 40);
      rsp_ready  = ($urandom_range(0, 99) < 60);
      @(negedge clk);
    end
    idle_cycles(8);

    done_req = 1'b1;
    for (int k = 0; k < 10 && !done_ack; k++) @(negedge clk);
    if (!done_ack) begin
      $display("FAIL monitor_done: actual no acknowledge required acknowledge");
      $fatal(1, "monitor did not finish");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
